// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back queue.
//   REG_ADDR_W : register-file address width
//   DATA_W     : data width carried by a queued entry (the top's WIDTH must match it)
//   XZR_ADDR   : zero register; writes to it are dropped before queuing
//   wb_entry_t : one pending register-file write {rd, data}
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 64;

  localparam logic [REG_ADDR_W-1:0] XZR_ADDR = 5'd31;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Bundle of the write-back queue's handshake, register-file write port and status signals.
//   master : the producer side (ALU/load paths, write-port availability, forwarding lookup)
//   slave  : the write-back queue itself
// The forwarding signals FwdRA/FwdHit/FwdData exist only when WB_FORWARD_EN is defined.
interface writeback_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic             AluValid;
  logic             AluReady;
  logic [4:0]       AluRd;
  logic [WIDTH-1:0] AluData;
  logic             MemValid;
  logic             MemReady;
  logic [4:0]       MemRd;
  logic [WIDTH-1:0] MemData;
  logic             WbEnable;
  logic [4:0]       RW;
  logic [WIDTH-1:0] BusW;
  logic             RegWr;
  logic [CntW-1:0]  Count;
  logic             Empty;
  logic             Full;
`ifdef WB_FORWARD_EN
  logic [4:0]       FwdRA;
  logic             FwdHit;
  logic [WIDTH-1:0] FwdData;
`endif

  modport master (
    output AluValid, AluRd, AluData, MemValid, MemRd, MemData, WbEnable,
    input  AluReady, MemReady, RW, BusW, RegWr, Count, Empty, Full
`ifdef WB_FORWARD_EN
    , output FwdRA
    , input  FwdHit, FwdData
`endif
  );

  modport slave (
    input  AluValid, AluRd, AluData, MemValid, MemRd, MemData, WbEnable,
    output AluReady, MemReady, RW, BusW, RegWr, Count, Empty, Full
`ifdef WB_FORWARD_EN
    , input  FwdRA
    , output FwdHit, FwdData
`endif
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order storage for pending register-file writes.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push_i         : enqueue push_entry_i (ignored when full)
//   pop_i          : dequeue the head (ignored when empty)
//   head_o         : oldest entry
//   count_o        : occupied entries; full_o / empty_o derived from it
//   rd_ptr_o       : index of the oldest entry, for walking entries_o in age order
//   entries_o      : raw view of every storage slot (used by the forwarding search)
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  wb_entry_t       push_entry_i,
  input  logic            pop_i,
  output wb_entry_t       head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [PtrW-1:0] rd_ptr_o,
  output wb_entry_t       entries_o [Depth]
);

  wb_entry_t       mem_q [Depth];
  wb_entry_t       mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

  // Guarding here keeps count within [0, Depth] whatever the caller does.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;  // Depth is a power of two: wraps naturally
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: slots are only ever read when count says they are live.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/writeback_queue.sv
// Buffered write-back producer for the 64-bit, 32-entry register file.
// Accepts ALU and load results over valid/ready, drops writes to X31, queues the rest in order
// and drives one registered write (RW/BusW/RegWr) per cycle while WbEnable is high.
//   Clk, ResetL : clock, asynchronous active-low reset
//   wb (slave)  : Alu*/Mem* handshakes, WbEnable, RW/BusW/RegWr, Count/Empty/Full,
//                 and FwdRA/FwdHit/FwdData when WB_FORWARD_EN is defined
// Optional feature macro: WB_FORWARD_EN (combinational lookup of the youngest pending write).
// WIDTH must equal wb_pkg::DATA_W.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic              Clk,
  input  logic              ResetL,
  writeback_queue_if.slave  wb
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic            full, empty;
  logic [CntW-1:0] count;
  logic [PtrW-1:0] rd_ptr;
  wb_entry_t       fifo_entries [DEPTH];
  wb_entry_t       head;
  wb_entry_t       push_entry;
  logic            mem_fire, alu_fire, push, pop;

  logic             regwr_q, regwr_d;
  logic [4:0]       rw_q, rw_d;
  logic [WIDTH-1:0] busw_q, busw_d;

  // Load path has fixed priority; ALU is held off whenever a load is offered.
  assign wb.MemReady = !full;
  assign wb.AluReady = !full && !wb.MemValid;

  assign mem_fire = wb.MemValid && !full;
  assign alu_fire = wb.AluValid && !full && !wb.MemValid;

  // X31 handshakes complete but never reach the queue.
  assign push = (mem_fire && (wb.MemRd != XZR_ADDR)) || (alu_fire && (wb.AluRd != XZR_ADDR));
  assign pop  = !empty && wb.WbEnable;

  always_comb begin
    push_entry = '0;
    if (wb.MemValid) begin
      push_entry.rd   = wb.MemRd;
      push_entry.data = wb.MemData;
    end else begin
      push_entry.rd   = wb.AluRd;
      push_entry.data = wb.AluData;
    end
  end

  wb_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i        (Clk),
    .rst_ni       (ResetL),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty),
    .rd_ptr_o     (rd_ptr),
    .entries_o    (fifo_entries)
  );

  // Registered write port: stable across the register file's negedge commit.
  always_comb begin
    regwr_d = pop;
    rw_d    = rw_q;
    busw_d  = busw_q;
    if (pop) begin
      rw_d   = head.rd;
      busw_d = head.data;
    end
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      regwr_q <= 1'b0;
      rw_q    <= '0;
      busw_q  <= '0;
    end else begin
      regwr_q <= regwr_d;
      rw_q    <= rw_d;
      busw_q  <= busw_d;
    end
  end

  assign wb.RegWr = regwr_q;
  assign wb.RW    = rw_q;
  assign wb.BusW  = busw_q;
  assign wb.Count = count;
  assign wb.Empty = empty;
  assign wb.Full  = full;

`ifdef WB_FORWARD_EN
  logic             fwd_hit;
  logic [WIDTH-1:0] fwd_data;
  logic [PtrW-1:0]  fwd_idx;

  // Lowest priority first (output stage), then queue oldest to youngest so the youngest
  // matching entry is the last one written.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (wb.FwdRA != XZR_ADDR) begin
      if (regwr_q && (rw_q == wb.FwdRA)) begin
        fwd_hit  = 1'b1;
        fwd_data = busw_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = rd_ptr + PtrW'(i);
        if ((CntW'(i) < count) && (fifo_entries[fwd_idx].rd == wb.FwdRA)) begin
          fwd_hit  = 1'b1;
          fwd_data = fifo_entries[fwd_idx].data;
        end
      end
    end
  end

  assign wb.FwdHit  = fwd_hit;
  assign wb.FwdData = fwd_data;
`else
  logic unused_fifo_view;

  always_comb begin
    unused_fifo_view = ^rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      unused_fifo_view = unused_fifo_view ^ (^fifo_entries[i]);
    end
  end
`endif

endmodule
